// File: rtl/udalt_pkg.sv
// Shared run-mode and direction encodings for the up/down/alternating counter.
// Imported by udalt_counter_gen and by anything that drives its mode port.
package udalt_pkg;

  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'b00,
    MODE_DOWN_WRAP = 2'b01,
    MODE_BOUNCE    = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/udalt_counter_gen.sv
// Up/down/bounce counter with run-time bounds, load, tc pulse and sat. laps.
// In: Clk, reset, en, load, load_val, mode, lo, hi. Out: count, dir, tc, laps, cfg_err.
module udalt_counter_gen
  import udalt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAP_W = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic [LAP_W-1:0] laps,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_tc;
  logic [LAP_W-1:0] r_laps;

  mode_e            w_mode;
  logic             w_cfg_err;
  logic             w_eff_dir;
  logic [WIDTH-1:0] w_clamp;
  logic [WIDTH-1:0] w_nxt_count;
  logic             w_nxt_dir;
  logic             w_nxt_tc;
  logic             w_lap_inc;
  logic             w_lap_clr;

  assign w_mode    = mode_e'(mode);
  assign w_cfg_err = (lo > hi);

  always_comb begin
    w_clamp = load_val;
    if (load_val < lo)
      w_clamp = lo;
    else if (load_val > hi)
      w_clamp = hi;
  end

  // Wrap modes force their direction; bounce follows the stored one.
  always_comb begin
    w_eff_dir = r_dir;
    case (w_mode)
      MODE_UP_WRAP:   w_eff_dir = DIR_UP;
      MODE_DOWN_WRAP: w_eff_dir = DIR_DOWN;
      default:        w_eff_dir = r_dir;
    endcase
  end

  always_comb begin
    w_nxt_count = r_count;
    w_nxt_dir   = r_dir;
    w_nxt_tc    = 1'b0;
    w_lap_inc   = 1'b0;
    w_lap_clr   = 1'b0;
    if (load) begin
      w_nxt_count = w_clamp;
      w_nxt_dir   = (w_mode == MODE_DOWN_WRAP) ? DIR_DOWN : DIR_UP;
      w_lap_clr   = 1'b1;
    end else if (w_cfg_err) begin
      w_nxt_tc = 1'b0;
    end else if (en && (w_mode != MODE_HOLD)) begin
      if (lo == hi) begin
        // Degenerate range: every step is a full lap.
        w_nxt_count = lo;
        w_nxt_tc    = 1'b1;
        w_lap_inc   = 1'b1;
      end else if ((r_count < lo) || (r_count > hi)) begin
        // Re-enter the range at the edge we are heading away from.
        w_nxt_count = (w_eff_dir == DIR_DOWN) ? hi : lo;
        w_nxt_dir   = w_eff_dir;
      end else begin
        if (w_eff_dir == DIR_UP) begin
          if (r_count != hi) begin
            w_nxt_count = r_count + ONE;
            w_nxt_dir   = DIR_UP;
          end else if (w_mode == MODE_BOUNCE) begin
            w_nxt_count = hi - ONE;
            w_nxt_dir   = DIR_DOWN;
          end else begin
            w_nxt_count = lo;
            w_nxt_dir   = DIR_UP;
            w_lap_inc   = 1'b1;
          end
        end else begin
          if (r_count != lo) begin
            w_nxt_count = r_count - ONE;
            w_nxt_dir   = DIR_DOWN;
          end else if (w_mode == MODE_BOUNCE) begin
            w_nxt_count = lo + ONE;
            w_nxt_dir   = DIR_UP;
            w_lap_inc   = 1'b1;
          end else begin
            w_nxt_count = hi;
            w_nxt_dir   = DIR_DOWN;
            w_lap_inc   = 1'b1;
          end
        end
        w_nxt_tc = ((w_nxt_dir == DIR_UP) && (w_nxt_count == hi)) ||
                   ((w_nxt_dir == DIR_DOWN) && (w_nxt_count == lo));
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_dir   <= DIR_UP;
      r_tc    <= 1'b0;
      r_laps  <= '0;
    end else begin
      r_count <= w_nxt_count;
      r_dir   <= w_nxt_dir;
      r_tc    <= w_nxt_tc;
      if (w_lap_clr)
        r_laps <= '0;
      else if (w_lap_inc && !(&r_laps))
        r_laps <= r_laps + LAP_W'(1);
    end
  end

  assign count   = r_count;
  assign dir     = r_dir;
  assign tc      = r_tc;
  assign laps    = r_laps;
  assign cfg_err = w_cfg_err;

endmodule

// File: tb/tb_udalt_counter_gen.sv
// Directed bench for udalt_counter_gen (WIDTH=4, LAP_W=8).
// Walks bounce, wrap, saturation, bound changes, reset, cfg_err, load and hold.
module tb_udalt_counter_gen;
  import udalt_pkg::*;

  logic       Clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic [1:0] mode;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] count;
  logic       dir;
  logic       tc;
  logic [7:0] laps;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;

  udalt_counter_gen #(.WIDTH(4), .LAP_W(8)) dut (
    .Clk      (Clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .lo       (lo),
    .hi       (hi),
    .count    (count),
    .dir      (dir),
    .tc       (tc),
    .laps     (laps),
    .cfg_err  (cfg_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic st(input string tag, input int c, input int d,
                    input int t, input int l);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".dir"},   32'(dir),   32'(d));
    chk({tag, ".tc"},    32'(tc),    32'(t));
    chk({tag, ".laps"},  32'(laps),  32'(l));
  endtask

  task automatic do_load(input logic [3:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    mode     = MODE_BOUNCE;
    lo       = 4'd0;
    hi       = 4'd15;
    #2;
    st("reset", 0, 0, 0, 0);
    chk("reset.cfg_err", 32'(cfg_err), 32'd0);
    tick();
    reset = 1'b0;
    en    = 1'b1;

    // Bounce 0..15..0..1
    for (int i = 1; i <= 15; i++) begin
      tick();
      st("bnc_up", i, 0, (i == 15) ? 1 : 0, 0);
    end
    for (int i = 14; i >= 0; i--) begin
      tick();
      st("bnc_dn", i, 1, (i == 0) ? 1 : 0, 0);
    end
    tick();
    st("bnc_ret", 1, 0, 0, 1);

    // Up wrap 3..6 with lap saturation
    mode = MODE_UP_WRAP;
    lo   = 4'd3;
    hi   = 4'd6;
    en   = 1'b0;
    do_load(4'd3);
    st("upw_load", 3, 0, 0, 0);
    en = 1'b1;
    tick(); st("upw4", 4, 0, 0, 0);
    tick(); st("upw5", 5, 0, 0, 0);
    tick(); st("upw6", 6, 0, 1, 0);
    tick(); st("upw3", 3, 0, 0, 1);
    repeat (254 * 4) tick();
    st("upw_sat", 3, 0, 0, 255);
    repeat (4) tick();
    st("upw_sat2", 3, 0, 0, 255);

    // Down wrap with clamped load
    mode = MODE_DOWN_WRAP;
    lo   = 4'd2;
    hi   = 4'd9;
    en   = 1'b0;
    do_load(4'd12);
    st("dnw_load", 9, 1, 0, 0);
    en = 1'b1;
    for (int i = 8; i >= 2; i--) begin
      tick();
      st("dnw", i, 1, (i == 2) ? 1 : 0, 0);
    end
    tick();
    st("dnw_wrap", 9, 1, 0, 1);

    // Bound change while bouncing, then lo==hi
    mode = MODE_BOUNCE;
    lo   = 4'd0;
    hi   = 4'd15;
    en   = 1'b0;
    do_load(4'd10);
    st("oor_load", 10, 0, 0, 0);
    hi = 4'd7;
    en = 1'b1;
    tick(); st("oor_step", 0, 0, 0, 0);
    lo = 4'd5;
    hi = 4'd5;
    tick(); st("eq1", 5, 0, 1, 1);
    tick(); st("eq2", 5, 0, 1, 2);
    en = 1'b0;
    tick(); st("eq_idle", 5, 0, 0, 2);

    // Async reset mid-cycle
    mode = MODE_UP_WRAP;
    lo   = 4'd0;
    hi   = 4'd15;
    do_load(4'd11);
    chk("pre_rst.count", 32'(count), 32'd11);
    #2;
    reset = 1'b1;
    #1;
    st("async_rst", 0, 0, 0, 0);
    reset = 1'b0;
    en    = 1'b1;
    tick();
    st("post_rst", 1, 0, 0, 0);

    // Bad bounds freeze the counter
    lo = 4'd8;
    hi = 4'd4;
    #1;
    chk("cfg_err.on", 32'(cfg_err), 32'd1);
    tick();
    st("cfg_freeze", 1, 0, 0, 0);

    // Build laps, then load beats en
    lo = 4'd6;
    hi = 4'd7;
    #1;
    chk("cfg_err.off", 32'(cfg_err), 32'd0);
    tick(); st("lap_a", 6, 0, 0, 0);
    tick(); st("lap_b", 7, 0, 1, 0);
    tick(); st("lap_c", 6, 0, 0, 1);
    tick(); st("lap_d", 7, 0, 1, 1);
    lo = 4'd0;
    hi = 4'd15;
    do_load(4'd2);
    st("load_en", 2, 0, 0, 0);

    // Clamp low on load
    lo = 4'd4;
    en = 1'b0;
    do_load(4'd1);
    st("clamp_lo", 4, 0, 0, 0);

    // Hold ignores en
    mode = MODE_HOLD;
    en   = 1'b1;
    tick(); st("hold1", 4, 0, 0, 0);
    tick(); st("hold2", 4, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
